// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants and helpers for the round-robin arbiter mux.
// Provides the reset pointer, output buffer depth and index-width function.
package rr_arb_pkg;

    // Priority pointer value after reset.
    localparam int RST_PTR   = 0;

    // Number of entries in the output buffer.
    localparam int BUF_DEPTH = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// rr_arb_core: pointer-based round-robin selector.
// Ports: req (requests), ptr (search start) -> grant (one-hot or zero),
// idx (index of the granted requester, 0 when nothing is requested).
module rr_arb_core #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [N-1:0] hi;
    logic [N-1:0] pick;

    always_comb begin
        hi = '0;
        for (int k = 0; k < N; k++) begin
            hi[k] = req[k] && (k >= int'(ptr));
        end
        // Requests at or above the pointer win; otherwise wrap to bit 0.
        pick = (|hi) ? hi : req;

        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pick[k]) begin
                idx = IW'(k);
            end
        end

        grant = '0;
        for (int k = 0; k < N; k++) begin
            grant[k] = pick[k] && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbiter over NUM_REQ bypass FIFOs feeding a
// 2-entry output buffer.
// Ports: CLK, Reset (async, active high); i_ReqVld/o_Grant request and
// grant per requester; i_Valid/i_Data return data one cycle after grant;
// o_Valid/o_Data/o_SrcId buffer head, popped by i_Ready.
// Build option: define RR_ARB_PROTO_CHECK_EN to add the sticky o_ProtoErr.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    parameter  int WIDTH   = 64,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       i_ReqVld,
    output logic [NUM_REQ-1:0]       o_Grant,
    input  logic [NUM_REQ-1:0]       i_Valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_Data,
    output logic                     o_Valid,
    output logic [WIDTH-1:0]         o_Data,
    output logic [IW-1:0]            o_SrcId,
    input  logic                     i_Ready
`ifdef RR_ARB_PROTO_CHECK_EN
    ,
    output logic                     o_ProtoErr
`endif
);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      sel_q;
    logic               inflight;
    logic [NUM_REQ-1:0] core_grant;
    logic [IW-1:0]      core_idx;
    logic               grant_en;
    logic               pop;
    logic               push;
    logic [2:0]         load;
    logic [2:0]         limit;
    logic               sel_vld;
    logic [WIDTH-1:0]   sel_data;

    logic [1:0]         occ;
    logic [WIDTH-1:0]   head_data;
    logic [IW-1:0]      head_src;
    logic [WIDTH-1:0]   tail_data;
    logic [IW-1:0]      tail_src;

    rr_arb_core #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_core (
        .req   (i_ReqVld),
        .ptr   (ptr),
        .grant (core_grant),
        .idx   (core_idx)
    );

    assign pop = o_Valid && i_Ready;

    // A grant reserves a buffer slot: count what is stored plus what is
    // still returning, minus what leaves this cycle.
    always_comb begin
        load     = 3'(occ) + 3'(inflight);
        limit    = 3'(BUF_DEPTH) + 3'(pop);
        grant_en = !Reset && (|i_ReqVld) && (load < limit);
        o_Grant  = grant_en ? core_grant : '0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ptr      <= IW'(RST_PTR);
            inflight <= 1'b0;
            sel_q    <= '0;
        end else begin
            inflight <= grant_en;
            if (grant_en) begin
                sel_q <= core_idx;
                if (core_idx == IW'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= core_idx + IW'(1);
                end
            end
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_q == IW'(k)) begin
                sel_vld  = i_Valid[k];
                sel_data = i_Data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A grant whose data never shows up simply frees its slot.
    assign push = inflight && sel_vld;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            occ       <= '0;
            head_data <= '0;
            head_src  <= '0;
            tail_data <= '0;
            tail_src  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= sel_data;
                        head_src  <= sel_q;
                    end else begin
                        tail_data <= sel_data;
                        tail_src  <= sel_q;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_src  <= tail_src;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= sel_data;
                        head_src  <= sel_q;
                    end else begin
                        head_data <= tail_data;
                        head_src  <= tail_src;
                        tail_data <= sel_data;
                        tail_src  <= sel_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Valid = (occ != 2'd0);
    assign o_Data  = head_data;
    assign o_SrcId = head_src;

`ifdef RR_ARB_PROTO_CHECK_EN
    logic [NUM_REQ-1:0] grant_q;

    // Sticky: missing data after a grant, or data nobody asked for.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            grant_q    <= '0;
            o_ProtoErr <= 1'b0;
        end else begin
            grant_q <= o_Grant;
            if ((inflight && !sel_vld) || (|(i_Valid & ~grant_q))) begin
                o_ProtoErr <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: self-checking bench for rr_arb_mux.
// Acts as the upstream FIFOs and scoreboards every buffered item.
module tb_rr_arb_mux;

    localparam int N  = 3;
    localparam int W  = 64;
    localparam int IW = 2;

    logic           CLK = 1'b0;
    logic           Reset;
    logic [N-1:0]   i_ReqVld;
    logic [N-1:0]   o_Grant;
    logic [N-1:0]   i_Valid;
    logic [N*W-1:0] i_Data;
    logic           o_Valid;
    logic [W-1:0]   o_Data;
    logic [IW-1:0]  o_SrcId;
    logic           i_Ready;
`ifdef RR_ARB_PROTO_CHECK_EN
    logic           proto_err;
`endif

    always #5 CLK = ~CLK;

    rr_arb_mux #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .i_ReqVld (i_ReqVld),
        .o_Grant  (o_Grant),
        .i_Valid  (i_Valid),
        .i_Data   (i_Data),
        .o_Valid  (o_Valid),
        .o_Data   (o_Data),
        .o_SrcId  (o_SrcId),
        .i_Ready  (i_Ready)
`ifdef RR_ARB_PROTO_CHECK_EN
        ,
        .o_ProtoErr (proto_err)
`endif
    );

    typedef struct {
        logic [IW-1:0] src;
        logic [W-1:0]  data;
    } exp_t;

    typedef struct {
        bit            rst;
        logic [N-1:0]  req;
        logic          rdy;
        logic [N-1:0]  g;
        logic          v;
        logic [IW-1:0] s;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[13];
    logic [W-1:0]  nxt[N];
    int            errs   = 0;
    int            checks = 0;
    bit            drop;
    bit            prev_stall;
    logic [W-1:0]  hold_d;
    logic [IW-1:0] hold_s;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    // One clock: sample at negedge, then answer grants after the posedge.
    task automatic cycle();
        logic [N-1:0] g;
        int k;
        @(negedge CLK);
        g = o_Grant;
        chk("grant_onehot0", 64'($onehot0(g)), 1);
        if (prev_stall) begin
            chk("hold_valid", o_Valid, 1);
            chk("hold_data", o_Data, hold_d);
            chk("hold_src", o_SrcId, hold_s);
        end
        prev_stall = o_Valid && !i_Ready;
        hold_d = o_Data;
        hold_s = o_SrcId;
        if (o_Valid && i_Ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", o_Valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", o_Data, e.data);
                chk("sb_src", o_SrcId, e.src);
            end
        end
        k = oh_idx(g);
        if ((|g) && !drop) begin
            sb.push_back('{src: IW'(k), data: nxt[k]});
        end
        @(posedge CLK);
        #1;
        i_Valid = drop ? '0 : g;
        i_Data  = '0;
        if (|g) begin
            i_Data[k*W +: W] = nxt[k];
            nxt[k] = nxt[k] + 1;
        end
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        i_Valid    = '0;
        i_ReqVld   = '0;
        i_Ready    = 1'b1;
        drop       = 1'b0;
        prev_stall = 1'b0;
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic drain();
        i_ReqVld = '0;
        i_Ready  = 1'b1;
        repeat (6) cycle();
        chk("sb_empty", 64'(sb.size()), 0);
    endtask

    initial begin
        Reset      = 1'b1;
        i_ReqVld   = 3'b111;
        i_Valid    = '0;
        i_Data     = '0;
        i_Ready    = 1'b1;
        drop       = 1'b0;
        prev_stall = 1'b0;
        for (int k = 0; k < N; k++) begin
            nxt[k] = 64'h1000 * (k + 1);
        end

        // Round robin, then backpressure (rst, req, rdy, grant, vld, src).
        tbl[0]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd0};
        tbl[6]  = '{1'b1, 3'b111, 1'b0, 3'b001, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd0};
        tbl[11] = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd1};
        tbl[12] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'd2};

        #3;
        chk("rst_grant", o_Grant, 0);
        chk("rst_valid", o_Valid, 0);
        chk("rst_data", o_Data, 0);
        chk("rst_src", o_SrcId, 0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            i_ReqVld = tbl[i].req;
            i_Ready  = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_grant", i), o_Grant, tbl[i].g);
            chk($sformatf("tbl%0d_valid", i), o_Valid, tbl[i].v);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_src", i), o_SrcId, tbl[i].s);
            end
            cycle();
        end
        drain();
`ifdef RR_ARB_PROTO_CHECK_EN
        chk("proto_clean", proto_err, 0);
`endif

        // Single requester at full rate.
        do_reset();
        nxt[2] = 64'hA0;
        for (int t = 0; t < 5; t++) begin
            i_ReqVld = (t < 3) ? 3'b100 : 3'b000;
            #1;
            chk($sformatf("single%0d_grant", t), o_Grant,
                (t < 3) ? 3'b100 : 3'b000);
            if (t >= 2) begin
                chk($sformatf("single%0d_valid", t), o_Valid, 1);
                chk($sformatf("single%0d_data", t), o_Data,
                    64'hA0 + 64'(t - 2));
            end else begin
                chk($sformatf("single%0d_valid", t), o_Valid, 0);
            end
            cycle();
        end
        drain();

        // Missing data after a grant to requester 1.
        do_reset();
        i_ReqVld = 3'b010;
        #1;
        chk("miss_grant", o_Grant, 3'b010);
        drop = 1'b1;
        cycle();
        drop = 1'b0;
        i_ReqVld = '0;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk($sformatf("miss%0d_valid", t), o_Valid, 0);
            cycle();
        end
`ifdef RR_ARB_PROTO_CHECK_EN
        chk("miss_proto_err", proto_err, 1);
`endif

        // Pointer persists across idle cycles.
        do_reset();
        i_ReqVld = 3'b001;
        #1;
        chk("ptr_first", o_Grant, 3'b001);
        cycle();
        i_ReqVld = '0;
        repeat (5) cycle();
        i_ReqVld = 3'b011;
        #1;
        chk("ptr_persist", o_Grant, 3'b010);
        cycle();
        drain();

        // Reset with a full buffer.
        do_reset();
        i_Ready  = 1'b0;
        i_ReqVld = 3'b111;
        repeat (4) cycle();
        chk("burst_full_valid", o_Valid, 1);
        Reset = 1'b1;
        #1;
        chk("mid_rst_grant", o_Grant, 0);
        chk("mid_rst_valid", o_Valid, 0);
        chk("mid_rst_data", o_Data, 0);
        chk("mid_rst_src", o_SrcId, 0);
        sb.delete();
        prev_stall = 1'b0;
        i_Valid  = '0;
        i_Ready  = 1'b1;
        i_ReqVld = 3'b110;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        #1;
        chk("post_rst_grant", o_Grant, 3'b010);
        cycle();
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of upstream bypass-FIFO requesters.
REQ-002 SHALL have parameter WIDTH, default 64: data width per requester.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_ReqVld  input  NUM_REQ  per-requester request, driven by each upstream FIFO's grant-request output.
REQ-006 SHALL have port o_Grant  output  NUM_REQ  one-hot or zero grant, combinational, to each upstream FIFO's grant input.
REQ-007 SHALL have port i_Valid  input  NUM_REQ  per-requester data-valid, arriving one cycle after that requester's grant.
REQ-008 SHALL have port i_Data  input  NUM_REQ*WIDTH  flattened requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port o_Valid  output  1  output buffer head valid.
REQ-010 SHALL have port o_Data  output  WIDTH  output buffer head data.
REQ-011 SHALL have port o_SrcId  output  clog2(NUM_REQ)  index of the requester that produced o_Data.
REQ-012 SHALL have port i_Ready  input  1  downstream accept; pop = o_Valid && i_Ready.

Function
REQ-013 SHALL grant at most one requester per cycle, chosen round-robin: search starts at the priority pointer, wraps modulo NUM_REQ.
REQ-014 SHALL, after a grant to index k, set the pointer to (k+1) mod NUM_REQ; no grant leaves the pointer unchanged.
REQ-015 SHALL issue a grant only if |i_ReqVld and (occ + inflight - pop) < 2, where occ is output buffer occupancy (0..2) and inflight marks a grant issued last cycle.
REQ-016 SHALL register inflight and the granted index (sel_q) on every grant; inflight clears the next cycle absent a new grant.
REQ-017 SHALL, when inflight and i_Valid[sel_q] is 1, push i_Data[sel_q] with SrcId = sel_q into a 2-entry FIFO output buffer.
REQ-018 SHALL, when inflight and i_Valid[sel_q] is 0, push nothing.
REQ-019 SHALL allow push and pop in the same cycle; occ stays unchanged.
REQ-020 SHALL, at occ = 2, never overflow: REQ-015 guarantees no push arrives without a slot.
REQ-021 SHALL sustain one transfer per cycle in steady state when i_Ready is held high and any request is held.
REQ-022 SHALL hold o_Valid, o_Data and o_SrcId stable while o_Valid && !i_Ready.
REQ-023 SHALL have latency from grant to o_Valid of 2 cycles when the buffer is empty.

Reset
REQ-024 SHALL on Reset clear: o_Grant=0, pointer=0, inflight=0, sel_q=0, occ=0, o_Valid=0, o_Data=0, o_SrcId=0.
REQ-025 SHALL discard in-flight and buffered data on reset mid-operation; the first grant after release goes to the lowest requesting index.

Configuration
REQ-026 SHALL, when RR_ARB_PROTO_CHECK_EN is defined, add output o_ProtoErr (1 bit, reset 0).
REQ-027 SHALL set o_ProtoErr and hold it until Reset in two cases: inflight && !i_Valid[sel_q], or any i_Valid bit set without a matching grant last cycle.
REQ-028 SHALL, when RR_ARB_PROTO_CHECK_EN is undefined, have no o_ProtoErr port and no checking logic.

Structure
REQ-029 SHALL take the reset pointer value, the buffer depth (2) and the index-width function from shared package rr_arb_pkg.
REQ-030 SHALL implement the pointer-based one-hot selector as sub-module rr_arb_core (inputs req and pointer, outputs one-hot grant and index).

Verification
REQ-031 SHALL verify round-robin order: i_ReqVld=3'b111 held, i_Ready=1, valid data returned each grant -> o_Grant sequence 001,010,100,001; o_SrcId 0,1,2,0.
REQ-032 SHALL verify single-requester throughput: only i_ReqVld[2]=1, data 0xA0,0xA1,0xA2 -> o_Grant=100 every cycle; o_Data 0xA0,0xA1,0xA2 on consecutive cycles starting 2 cycles after the first grant.
REQ-033 SHALL verify backpressure: i_Ready=0 with requests pending -> exactly 2 grants, then o_Grant=0; o_Valid=1 with the first item held stable; after i_Ready rises, grants resume with no loss or duplication.
REQ-034 SHALL verify the missing-valid case: grant to index 1 with i_Valid[1]=0 next cycle -> occ unchanged, no o_Valid, and o_ProtoErr=1 with RR_ARB_PROTO_CHECK_EN defined.
REQ-035 SHALL verify pointer persistence: grant index 0, idle 5 cycles, then i_ReqVld=3'b011 -> grant goes to index 1.
REQ-036 SHALL verify reset mid-burst: assert Reset while occ=2 -> all outputs 0 immediately; after release with i_ReqVld=3'b110, the first grant is index 1.
